// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO, with flush cancel
//   clk, reset (async, active-high); start/op/In1/In2 request (sampled only while idle);
//   cancel aborts an in-flight mul/div; busy stalls HI/LO readers; done pulses when a result lands;
//   hi/lo are the architectural HI/LO registers.
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, negr_q, negr_d, done_q, done_d;
  logic [WIDTH-1:0] b_q, b_d, ph_q, ph_d, pl_q, pl_d, hi_q, hi_d, lo_q, lo_d;
  logic s1, s2;
  logic [WIDTH-1:0] m1, m2;
  logic [WIDTH:0] sum, r, diff;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    s1 = ~op[0] & In1[WIDTH-1];
    s2 = ~op[0] & In2[WIDTH-1];
    m1 = s1 ? -In1 : In1;
    m2 = s2 ? -In2 : In2;
    // ph:pl is the product (mul) or remainder:dividend/quotient (div); b is multiplicand or divisor
    sum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, b_q} : '0);
    r = {ph_q, pl_q[WIDTH-1]};
    // diff[WIDTH] set means the trial subtraction borrowed, so the remainder is restored
    diff = r - {1'b0, b_q};
    prod = neg_q ? -{ph_q, pl_q} : {ph_q, pl_q};
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    neg_d = neg_q;
    negr_d = negr_q;
    b_d = b_q;
    ph_d = ph_q;
    pl_d = pl_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel && !op[2]) begin
          state_d = CALC;
          cnt_d = CW'(WIDTH - 1);
          div_d = op[1];
          neg_d = s1 ^ s2;
          negr_d = s1;
          b_d = op[1] ? m2 : m1;
          ph_d = '0;
          pl_d = op[1] ? m1 : m2;
        end else if (start && !cancel && op[2:1] == 2'b10) begin
          hi_d = op[0] ? hi_q : In1;
          lo_d = op[0] ? In1 : lo_q;
        end
      end
      CALC: begin
        state_d = cancel ? IDLE : (cnt_q == '0 ? FIX : CALC);
        cnt_d = cnt_q - 1'b1;
        ph_d = div_q ? (diff[WIDTH] ? r[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        pl_d = div_q ? {pl_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], pl_q[WIDTH-1:1]};
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          // a zero divisor leaves the dividend in ph, so only the quotient needs overriding
          hi_d = div_q ? (negr_q ? -ph_q : ph_q) : prod[2*WIDTH-1:WIDTH];
          lo_d = div_q ? (b_q == '0 ? '1 : (neg_q ? -pl_q : pl_q)) : prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      negr_q <= 1'b0;
      done_q <= 1'b0;
      b_q <= '0;
      ph_q <= '0;
      pl_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      neg_q <= neg_d;
      negr_q <= negr_d;
      done_q <= done_d;
      b_q <= b_d;
      ph_q <= ph_d;
      pl_q <= pl_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: scoreboard bench for alu_muldiv_unit with a plain-arithmetic reference model
module tb_alu_muldiv_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] in1 = '0, in2 = '0, hi, lo;
  logic busy, done;
  logic s8 = 1'b0;
  logic [2:0] op8 = 3'd0;
  logic [7:0] a8 = '0, b8 = '0, hi8, lo8;
  logic busy8, done8;
  int checks = 0, failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi = '0, m_lo = '0;

  alu_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .start(start), .op(op), .In1(in1),
    .In2(in2), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));
  alu_muldiv_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(s8), .op(op8), .In1(a8),
    .In2(b8), .cancel(1'b0), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return 64'(longint'($signed(a)) * longint'($signed(b)));
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("result", {hi, lo}, mon_e);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input logic [63:0] e);
    int n = n0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'd34);
    {m_hi, m_lo} = e;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e = model(o, a, b);
    exp_q.push_back(e);
    issue(o, a, b);
    wait_done(1, e);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    issue(o, a, 32'd0);
    if (o == 3'd4) m_hi = a; else m_lo = a;
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_regs", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int n = 1;
    s8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk); #1;
    s8 = 1'b0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency8", 64'(n), 64'd10);
    chk("result8", {48'd0, hi8, lo8}, {48'd0, e});
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(3'd3, 32'd100, 32'd7);
    chk("divu", {hi, lo}, {32'd2, 32'd14});
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd3, 32'd5, 32'd0);
    chk("divu_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run(3'd2, 32'hFFFF_FFF6, 32'd0);
    mt(3'd4, 32'h1234);
    mt(3'd5, 32'hCAFE_F00D);
    // MTLO while a multiply is in flight must be dropped
    e = model(3'd1, 32'd3, 32'd4);
    exp_q.push_back(e);
    issue(3'd1, 32'd3, 32'd4);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    chk("mtlo_busy_ignored", {32'd0, lo}, {32'd0, m_lo});
    wait_done(2, e);
    // restart in the done cycle
    run(3'd0, 32'd11, 32'hFFFF_FFFE);
    run(3'd3, 32'd1000, 32'd33);
    // cancel mid-CALC
    issue(3'd2, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_regs", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(posedge clk); #1;
    chk("cancel_regs_late", {hi, lo}, {m_hi, m_lo});
    // flush in IDLE drops the same-cycle start
    cancel = 1'b1;
    issue(3'd4, 32'h5555_AAAA, 32'd0);
    cancel = 1'b0;
    chk("cancel_idle_mthi", {hi, lo}, {m_hi, m_lo});
    chk("cancel_idle_busy", {63'd0, busy}, 64'd0);
    // reserved ops are no-ops
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    issue(3'd7, 32'h3333_3333, 32'h4444_4444);
    chk("reserved_op", {31'd0, busy, hi, lo[30:0]}, {31'd0, 1'b0, m_hi, m_lo[30:0]});
    for (int i = 0; i < 40; i++) begin
      a = (i % 9 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run(3'($urandom_range(0, 3)), a, b);
    end
    run8(3'd0, 8'h80, 8'h80, 16'h4000);
    run8(3'd2, 8'h80, 8'hFF, 16'h0080);
    // asynchronous reset in the middle of CALC
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_mid_calc", {31'd0, busy, hi, lo[31:1]}, 64'd0);
    chk("reset_lo0", {63'd0, lo[0]}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("after_reset_idle", {31'd0, busy, hi, lo[31:1]}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
